train_led_rx_pwm: RTL and testbench

- Parametrised single-wire daisy-chain LED node: successor to the 1-channel, 4-bit train receiver.
- Decodes pulse-width-coded bits on din and captures CHANNELS x PWM_BITS bits per frame.
- Then regenerates and forwards all further bits on dout to the next node.
- Drives CHANNELS glitch-free PWM outputs, all updated together; adds input synchronizer, double-buffered duty registers, saturating idle timer and a frame-done strobe.

---
 rtl/train_led_rx_pwm.sv | 154 +++++++++++++++
 tb/tb_train_led_rx_pwm.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/train_led_rx_pwm.sv
// Daisy-chain LED node: captures one frame of pulse-width-coded duty bits from din,
// regenerates every later bit on dout, and drives CHANNELS PWM outputs.
module train_led_rx_pwm #(
   parameter int unsigned CHANNELS     = 3,
   parameter int unsigned PWM_BITS     = 4,
   parameter int unsigned BIT_CYCLES   = 12,
   parameter int unsigned START_FILT   = 2,
   parameter int unsigned SAMPLE_POINT = 6,
   parameter int unsigned IDLE_RESET   = 96,
   parameter int unsigned IDLE_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                din,
   output logic                dout,
   output logic [CHANNELS-1:0] led,
   output logic                frame_done,
   output logic                fwd_mode
);
   localparam int unsigned PH_W       = $clog2(BIT_CYCLES);
   localparam int unsigned FRAME_BITS = CHANNELS * PWM_BITS;
   localparam int unsigned BC_W       = $clog2(FRAME_BITS + 1);

   localparam logic [PH_W-1:0]   PH_TOP    = PH_W'(BIT_CYCLES - 1);
   localparam logic [PH_W-1:0]   PH_FILT   = PH_W'(START_FILT);
   localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(SAMPLE_POINT);
   localparam logic [PH_W-1:0]   PH_DROP   = PH_W'(BIT_CYCLES - 2);
   localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(FRAME_BITS - 1);
   localparam logic [IDLE_W-1:0] IDLE_HIT  = IDLE_W'(IDLE_RESET);

   typedef enum logic {MODE_RX = 1'b0, MODE_FWD = 1'b1} mode_e;

   mode_e                 mode_q, mode_d;
   logic [1:0]            sync_q, sync_d;
   logic [PH_W-1:0]       ph_q, ph_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [BC_W-1:0]       bcnt_q, bcnt_d;
   logic [IDLE_W-1:0]     idle_q, idle_d;
   logic [FRAME_BITS-1:0] shadow_q, shadow_d;
   logic [FRAME_BITS-1:0] active_q, active_d;
   logic [PWM_BITS-1:0]   cnt_q, cnt_d;
   logic [CHANNELS-1:0]   led_q, led_d;
   logic                  dout_q, dout_d;
   logic                  frame_done_q, frame_done_d;
   logic                  din_s;
   logic                  sample;

   assign din_s      = sync_q[1];
   assign sample     = (ph_q == PH_SAMPLE);
   assign dout       = dout_q;
   assign led        = led_q;
   assign frame_done = frame_done_q;
   assign fwd_mode   = (mode_q == MODE_FWD);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q       <= MODE_RX;
         sync_q       <= '0;
         ph_q         <= '0;
         shift_q      <= '0;
         bcnt_q       <= '0;
         idle_q       <= '0;
         shadow_q     <= '0;
         active_q     <= '0;
         cnt_q        <= '0;
         led_q        <= '0;
         dout_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         sync_q       <= sync_d;
         ph_q         <= ph_d;
         shift_q      <= shift_d;
         bcnt_q       <= bcnt_d;
         idle_q       <= idle_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         cnt_q        <= cnt_d;
         led_q        <= led_d;
         dout_q       <= dout_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state: bit timing, capture/forward mode, idle timer and PWM
   always_comb begin
      mode_d       = mode_q;
      sync_d       = {sync_q[0], din};
      ph_d         = ph_q;
      shift_d      = shift_q;
      bcnt_d       = bcnt_q;
      idle_d       = idle_q;
      shadow_d     = shadow_q;
      active_d     = active_q;
      cnt_d        = cnt_q + 1'b1;
      led_d        = led_q;
      dout_d       = dout_q;
      frame_done_d = 1'b0;

      // Once past the start filter a bit slot runs to completion regardless of din_s
      if (ph_q >= PH_FILT && ph_q < PH_TOP) begin
         ph_d = ph_q + 1'b1;
      end else if (din_s && ph_q < PH_FILT) begin
         ph_d = ph_q + 1'b1;
      end else if (!din_s) begin
         ph_d = '0;
      end

      unique case (mode_q)
         MODE_RX: begin
            dout_d = 1'b0;
            if (sample) begin
               shift_d = {shift_q[FRAME_BITS-2:0], din_s};
               bcnt_d  = bcnt_q + 1'b1;
               if (bcnt_q == BC_LAST) begin
                  shadow_d     = shift_d;
                  frame_done_d = 1'b1;
                  mode_d       = MODE_FWD;
               end
            end
         end
         MODE_FWD: begin
            if (ph_q == PH_FILT) begin
               dout_d = 1'b1;
            end else if (sample) begin
               dout_d = din_s;
            end else if (ph_q == PH_DROP) begin
               dout_d = 1'b0;
            end
         end
         default: mode_d = MODE_RX;
      endcase

      if (ph_q <= PH_FILT) begin
         idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
      end else begin
         idle_d = '0;
      end

      // A quiet line ends the session; an unfinished frame is simply dropped
      if (idle_q == IDLE_HIT) begin
         mode_d = MODE_RX;
         bcnt_d = '0;
      end

      if (cnt_q == '1) begin
         active_d = shadow_q;
      end
      for (int i = 0; i < CHANNELS; i++) begin
         led_d[i] = (cnt_q < active_q[FRAME_BITS-1-i*PWM_BITS -: PWM_BITS]);
      end
   end
endmodule

// File: tb/tb_train_led_rx_pwm.sv
// Self-checking bench for train_led_rx_pwm: fixed frame table, hand-written corner
// sequences and randomized frames checked against a frame/duty reference model.
module tb_train_led_rx_pwm;
   localparam int unsigned CH  = 3;
   localparam int unsigned PW  = 4;
   localparam int unsigned FB  = CH * PW;
   localparam int unsigned CH2 = 4;
   localparam int unsigned PW2 = 6;
   localparam int unsigned FB2 = CH2 * PW2;
   // Forwarded pulse: rises START_FILT+1 after din_s; a 1 drops at phase BIT_CYCLES-2, a 0 at SAMPLE_POINT
   localparam int PULSE1 = 12 - 2 - 2;
   localparam int PULSE0 = 6 - 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic dout, fd, fwd;
   logic [CH-1:0] led;
   logic dout2, fd2, fwd2;
   logic [CH2-1:0] led2;

   always #5 clk = ~clk;

   train_led_rx_pwm u_dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout),
      .led(led), .frame_done(fd), .fwd_mode(fwd)
   );

   train_led_rx_pwm #(.CHANNELS(CH2), .PWM_BITS(PW2)) u_dut2 (
      .clk(clk), .rst(rst), .din(din), .dout(dout2),
      .led(led2), .frame_done(fd2), .fwd_mode(fwd2)
   );

   int checks = 0;
   int failures = 0;

   int fd_cnt = 0;
   int fd2_cnt = 0;
   int rise_cnt = 0;
   int cur_len = 0;
   int plen[$];
   logic dprev = 1'b0;

   always @(negedge clk) begin
      if (fd) fd_cnt++;
      if (fd2) fd2_cnt++;
      if (dout && !dprev) begin
         rise_cnt++;
         cur_len = 1;
      end else if (dout) begin
         cur_len++;
      end else if (dprev) begin
         plen.push_back(cur_len);
      end
      dprev = dout;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: first bit sent is frame[fb-1]; channel ch takes the ch-th group of pw bits
   function automatic int duty(input logic [63:0] f, input int fb, input int pw, input int ch);
      logic [63:0] mask;
      mask = (64'd1 << pw) - 64'd1;
      return int'((f >> (fb - pw * (ch + 1))) & mask);
   endfunction

   task automatic send_bit(input logic b, input bit rnd);
      int hi, lo;
      if (rnd) begin
         hi = b ? int'($urandom_range(10, 7)) : int'($urandom_range(6, 3));
         lo = 14 - hi + int'($urandom_range(2, 0));
      end else begin
         hi = b ? 8 : 4;
         lo = 14 - hi;
      end
      din = 1'b1;
      repeat (hi) @(negedge clk);
      din = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_frame(input logic [63:0] f, input int n, input bit rnd);
      for (int k = n - 1; k >= 0; k--) send_bit(f[k], rnd);
   endtask

   task automatic glitch();
      din = 1'b1;
      @(negedge clk);
      din = 1'b0;
   endtask

   task automatic check_led1(input int e0, input int e1, input int e2, input string tag);
      int c[CH];
      int e[CH];
      e[0] = e0; e[1] = e1; e[2] = e2;
      for (int i = 0; i < CH; i++) c[i] = 0;
      repeat (16) begin
         @(negedge clk);
         for (int i = 0; i < CH; i++) if (led[i]) c[i]++;
      end
      for (int i = 0; i < CH; i++) chk($sformatf("%s led%0d high/16", tag, i), c[i], e[i]);
   endtask

   task automatic check_led2(input logic [63:0] f, input string tag);
      int c[CH2];
      for (int i = 0; i < CH2; i++) c[i] = 0;
      repeat (64) begin
         @(negedge clk);
         for (int i = 0; i < CH2; i++) if (led2[i]) c[i]++;
      end
      for (int i = 0; i < CH2; i++)
         chk($sformatf("%s led2_%0d high/64", tag, i), c[i], duty(f, FB2, PW2, i));
   endtask

   task automatic fwd_check(input logic [63:0] bits, input int n, input bit rnd, input string tag);
      int r0, act;
      plen.delete();
      r0 = rise_cnt;
      send_frame(bits, n, rnd);
      repeat (2) @(negedge clk);
      chk({tag, " dout pulses"}, rise_cnt - r0, n);
      for (int j = 0; j < n; j++) begin
         act = (j < plen.size()) ? plen[j] : -1;
         chk($sformatf("%s pulse%0d len", tag, j), act, bits[n-1-j] ? PULSE1 : PULSE0);
      end
   endtask

   typedef struct {
      logic [11:0] frame;
      int          partial;
      logic [11:0] pbits;
      int          d0;
      int          d1;
      int          d2;
   } vec_t;

   vec_t tbl[3];

   initial begin
      logic [63:0] f;
      logic [63:0] g;
      int f0, f2, r0, n;

      tbl[0] = '{12'b1010_0110_1111, 0, 12'h000, 10, 6, 15};
      tbl[1] = '{12'b0001_0000_1000, 0, 12'h000, 1, 0, 8};
      tbl[2] = '{12'b0011_0011_0011, 7, 12'b000001011010, 3, 3, 3};

      repeat (3) @(negedge clk);
      chk("reset dout", dout, 0);
      chk("reset led", led, 0);
      chk("reset frame_done", fd, 0);
      chk("reset fwd_mode", fwd, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int k = 0; k < 3; k++) begin
         if (tbl[k].partial > 0) begin
            f0 = fd_cnt;
            send_frame(64'(tbl[k].pbits), tbl[k].partial, 1'b0);
            repeat (110) @(negedge clk);
            chk($sformatf("v%0d partial frame_done", k), fd_cnt - f0, 0);
            chk($sformatf("v%0d partial fwd_mode", k), fwd, 0);
         end
         f0 = fd_cnt;
         send_frame(64'(tbl[k].frame), 12, 1'b0);
         chk($sformatf("v%0d frame_done pulses", k), fd_cnt - f0, 1);
         chk($sformatf("v%0d fwd_mode after frame", k), fwd, 1);
         repeat (40) @(negedge clk);
         check_led1(tbl[k].d0, tbl[k].d1, tbl[k].d2, $sformatf("v%0d", k));
         fwd_check(64'b10011, 5, 1'b0, $sformatf("v%0d fwd", k));
         check_led1(tbl[k].d0, tbl[k].d1, tbl[k].d2, $sformatf("v%0d post-fwd", k));
         repeat (40) @(negedge clk);
         chk($sformatf("v%0d fwd_mode before idle", k), fwd, 1);
         repeat (50) @(negedge clk);
         chk($sformatf("v%0d fwd_mode after idle", k), fwd, 0);
      end

      // din rise to dout rise: 2 sync stages + START_FILT + 1
      send_frame(64'hA5C, 12, 1'b1);
      din = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (dout) begin
            n = i;
            break;
         end
      end
      chk("dout latency from din", n, 5);
      if (n < 8) repeat (8 - n) @(negedge clk);
      din = 1'b0;
      repeat (130) @(negedge clk);
      chk("latency seq fwd_mode idle", fwd, 0);

      // single-cycle glitches inside a frame must not count as bits
      f = 64'($urandom_range(4095, 0));
      f0 = fd_cnt;
      send_frame(f >> 6, 6, 1'b1);
      repeat (2) begin
         repeat (12) @(negedge clk);
         glitch();
      end
      repeat (12) @(negedge clk);
      send_frame(f & 64'h3F, 6, 1'b1);
      chk("glitch rx frame_done", fd_cnt - f0, 1);
      repeat (40) @(negedge clk);
      check_led1(duty(f, FB, PW, 0), duty(f, FB, PW, 1), duty(f, FB, PW, 2), "glitch rx");

      // glitches in forward mode: no dout activity and the idle timer keeps running
      r0 = rise_cnt;
      repeat (8) begin
         repeat (15) @(negedge clk);
         glitch();
      end
      repeat (5) @(negedge clk);
      chk("glitch fwd dout pulses", rise_cnt - r0, 0);
      chk("glitch fwd idle expiry", fwd, 0);

      for (int k = 0; k < 5; k++) begin
         f = 64'($urandom_range(4095, 0));
         g = 64'($urandom_range(7, 0));
         f0 = fd_cnt;
         send_frame(f, 12, 1'b1);
         chk($sformatf("r%0d frame_done", k), fd_cnt - f0, 1);
         repeat (40) @(negedge clk);
         check_led1(duty(f, FB, PW, 0), duty(f, FB, PW, 1), duty(f, FB, PW, 2),
                    $sformatf("r%0d", k));
         fwd_check(g, 3, 1'b1, $sformatf("r%0d fwd", k));
         repeat (120) @(negedge clk);
         chk($sformatf("r%0d fwd_mode idle", k), fwd, 0);
      end

      // asynchronous reset in the middle of a forwarded bit
      send_frame(64'hFFF, 12, 1'b0);
      repeat (40) @(negedge clk);
      din = 1'b1;
      repeat (6) @(negedge clk);
      chk("pre-reset dout", dout, 1);
      #2 rst = 1'b1;
      #1;
      chk("async rst dout", dout, 0);
      chk("async rst fwd_mode", fwd, 0);
      chk("async rst led", led, 0);
      din = 1'b0;
      @(negedge clk);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      f = 64'($urandom_range(32'hFFFFFF, 0));
      r0 = rise_cnt;
      f0 = fd_cnt;
      f2 = fd2_cnt;
      send_frame(f >> 12, 12, 1'b1);
      chk("post-rst captured not forwarded", rise_cnt - r0, 0);
      chk("post-rst frame_done", fd_cnt - f0, 1);
      chk("post-rst fwd_mode", fwd, 1);
      fwd_check(f & 64'hFFF, 12, 1'b1, "post-rst fwd");
      chk("wide frame_done", fd2_cnt - f2, 1);
      chk("wide fwd_mode", fwd2, 1);
      repeat (70) @(negedge clk);
      check_led1(duty(f >> 12, FB, PW, 0), duty(f >> 12, FB, PW, 1), duty(f >> 12, FB, PW, 2),
                 "post-rst");
      check_led2(f, "wide");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
